// File: rtl/instruction_fetch.sv
// Fetch stage: byte PC driving a word-addressed instruction memory,
// IF/ID capture with stall, flush, redirect and a sticky address-fault trap.
module instruction_fetch #(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] imem_address,
  input  logic [31:0]           imem_instruction,
  output logic [31:0]           if_id_instruction,
  output logic [PC_WIDTH-1:0]   if_id_pc,
  output logic [PC_WIDTH-1:0]   if_id_pc_plus4,
  output logic                  if_id_valid,
  output logic                  fault,
  output logic [PC_WIDTH-1:0]   fault_pc
);

  typedef enum logic {
    RUN,
    FAULT
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         instr_q, instr_d;
  logic [PC_WIDTH-1:0] ipc_q, ipc_d;
  logic [PC_WIDTH-1:0] ipc4_q, ipc4_d;
  logic                valid_q, valid_d;
  logic                fault_q, fault_d;
  logic [PC_WIDTH-1:0] fpc_q, fpc_d;

  logic [PC_WIDTH-1:0] pc_plus4;
  logic                redir_bad;
  logic                seq_bad;

  assign pc_plus4  = pc_q + PC_WIDTH'(4);
  assign redir_bad = (redirect_pc[1:0] != 2'b00) ||
                     (redirect_pc[PC_WIDTH-1:ADDR_WIDTH+2] != '0);
  // An advance that leaves the memory window traps instead of wrapping.
  assign seq_bad   = pc_plus4[PC_WIDTH-1:ADDR_WIDTH+2] != '0;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ipc4_d  = ipc4_q;
    valid_d = valid_q;
    fault_d = fault_q;
    fpc_d   = fpc_q;
    unique case (state_q)
      RUN: begin
        if (redirect) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          if (redir_bad) begin
            state_d = FAULT;
            fault_d = 1'b1;
            fpc_d   = redirect_pc;
          end else begin
            pc_d = redirect_pc;
          end
        end else if (flush || !stall) begin
          if (flush) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
          end else begin
            instr_d = imem_instruction;
            ipc_d   = pc_q;
            ipc4_d  = pc_plus4;
            valid_d = 1'b1;
          end
          if (!stall) begin
            if (seq_bad) begin
              state_d = FAULT;
              fault_d = 1'b1;
              fpc_d   = pc_plus4;
            end else begin
              pc_d = pc_plus4;
            end
          end
        end
      end
      FAULT: begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      ipc_q   <= '0;
      ipc4_q  <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      fpc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc4_q  <= ipc4_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      fpc_q   <= fpc_d;
    end
  end

  assign imem_address      = pc_q[ADDR_WIDTH+1:2];
  assign if_id_instruction = instr_q;
  assign if_id_pc          = ipc_q;
  assign if_id_pc_plus4    = ipc4_q;
  assign if_id_valid       = valid_q;
  assign fault             = fault_q;
  assign fault_pc          = fpc_q;

endmodule
